pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised next-generation program-counter unit for the i281 fetch stage.
- Replaces the load-only PC register with on-chip next-PC selection: sequential increment, PC-relative branch, absolute jump, call/return with an internal return-address stack (RAS), and pipeline stall.
- Drives the instruction-memory address and exposes the next-cycle PC for prefetch.

Parameters:
- PC_W, 6, PC and address width in bits.
- RESET_VEC, 32, PC value loaded on reset; truncated to PC_W bits.
- OFF_W, 6, width of the signed branch offset; must be <= PC_W.
- RAS_DEPTH, 4, number of return-address stack entries; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC, RAS and flags this cycle.
- br_taken  input  1  take PC-relative branch.
- br_offset  input  OFF_W  two's-complement branch offset.
- jmp_en  input  1  absolute jump.
- call_en  input  1  call: push return address, then jump.
- ret_en  input  1  return: pop RAS into PC.
- jmp_target  input  PC_W  target for jmp_en and call_en.
- pc_out  output  PC_W  current PC (registered).
- pc_next  output  PC_W  value PC takes at the next edge (combinational).
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_overflow  output  1  sticky: a call was made with the RAS full.
- ras_underflow  output  1  sticky: a return was made with the RAS empty.

Behaviour:
- Reset (sampled on posedge clk, wins over everything):
  - pc_out = RESET_VEC; RAS count = 0.
  - ras_empty = 1, ras_full = 0, ras_overflow = 0, ras_underflow = 0.
  - pc_next = RESET_VEC while reset is high.
- Let inc = pc_out + 1, computed mod 2^PC_W.
- Each non-reset edge applies exactly one action, in this priority order:
  - 1) stall: PC, RAS contents, count and flags all hold.
  - 2) ret_en:
    - count > 0: PC <= top entry; count decrements.
    - count = 0: PC <= inc; ras_underflow set to 1.
  - 3) call_en: push inc; PC <= jmp_target.
    - Full RAS: the oldest entry is discarded (circular buffer), count stays RAS_DEPTH, ras_overflow set to 1, and the push still happens.
  - 4) jmp_en: PC <= jmp_target.
  - 5) br_taken: PC <= inc + sign_extend(br_offset), mod 2^PC_W. Branches are relative to PC+1.
  - 6) none of the above: PC <= inc.
- Lower-priority requests asserted in the same cycle as a higher-priority one are ignored, not queued.
- pc_next always equals the value pc_out holds after the coming edge:
  - pc_next = pc_out when stall = 1.
  - pc_next = RESET_VEC when reset = 1.
- Latency: any control input is visible on pc_out one cycle later. No internal state beyond the PC register, the RAS storage, the count and the two sticky flags.
- Status flags:
  - ras_empty and ras_full are registered and derived from count.
  - Sticky flags clear only on reset.
- Wrap-around:
  - At PC = 2^PC_W-1, increment gives 0.
  - A branch result is taken modulo 2^PC_W; no overflow flag is raised.
- A call and a return never occur together: ret_en wins, so no simultaneous push/pop is needed.
- Reset asserted mid-sequence (for example with a full RAS) discards all entries in the same edge.

Test Plan:
- Reset, then 3 free-running cycles -> pc_out 32, 33, 34, 35; ras_empty = 1, all other flags 0.
- At PC = 40: br_taken with br_offset = -5 (6'b111011) -> PC 36. At PC = 63 with no control asserted -> PC 0 (wrap).
- At PC = 10: call_en with jmp_target = 50 -> PC 50, RAS top = 11. Two cycles later ret_en -> PC 11, ras_empty = 1.
- Five nested calls at PCs 1, 2, 3, 4, 5 (RAS_DEPTH = 4) -> ras_full = 1 and ras_overflow = 1. Four returns yield 6, 5, 4, 3. A fifth return gives inc and sets ras_underflow = 1.
- stall asserted together with call_en, jmp_en and br_taken for 3 cycles -> pc_out, RAS and flags unchanged; pc_next = pc_out. With ret_en + call_en + jmp_en in the same cycle -> only the pop occurs.
- Reset asserted with the RAS full and both sticky flags set -> next cycle pc_out = 32, count 0, all flags 0. A following ret_en gives PC 33 and sets ras_underflow.

Source files
------------

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with next-PC select and return-address stack
module pc_unit #(
  parameter int PC_W      = 6,
  parameter int RESET_VEC = 32,
  parameter int OFF_W     = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [OFF_W-1:0] br_offset,
  input  logic             jmp_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [PC_W-1:0]  jmp_target,
  output logic [PC_W-1:0]  pc_out,
  output logic [PC_W-1:0]  pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_VEC);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  inc;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  top_entry;
  logic [PC_W-1:0]  pc_sel;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  // wr_ptr is the slot the next push lands in; when full it points at the oldest entry
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_q, ovf_nxt;
  logic             unf_q, unf_nxt;
  logic             empty_q, full_q;
  logic             push;

  // Sign-extend the branch offset to PC width
  generate
    if (PC_W > OFF_W) begin : g_sext
      assign off_ext = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
    end else begin : g_nosext
      assign off_ext = br_offset;
    end
  endgenerate

  assign inc       = pc_q + PC_W'(1);
  assign top_idx   = (wr_ptr == '0) ? LAST_IDX : wr_ptr - PTR_W'(1);
  assign top_entry = ras_mem[top_idx];

  // Next-PC and RAS update selection; one action per edge, highest priority first
  always_comb begin
    pc_sel     = inc;
    cnt_nxt    = cnt;
    wr_ptr_nxt = wr_ptr;
    push       = 1'b0;
    ovf_nxt    = ovf_q;
    unf_nxt    = unf_q;
    if (stall) begin
      pc_sel = pc_q;
    end else if (ret_en) begin
      if (cnt != '0) begin
        pc_sel     = top_entry;
        cnt_nxt    = cnt - CNT_W'(1);
        wr_ptr_nxt = top_idx;
      end else begin
        unf_nxt = 1'b1;
      end
    end else if (call_en) begin
      push       = 1'b1;
      pc_sel     = jmp_target;
      wr_ptr_nxt = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
      if (cnt == FULL_CNT) begin
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else if (jmp_en) begin
      pc_sel = jmp_target;
    end else if (br_taken) begin
      pc_sel = inc + off_ext;
    end
  end

  assign pc_next = reset ? RESET_PC : pc_sel;

  // PC, stack bookkeeping and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      cnt     <= '0;
      wr_ptr  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      pc_q    <= pc_sel;
      cnt     <= cnt_nxt;
      wr_ptr  <= wr_ptr_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
      empty_q <= (cnt_nxt == '0);
      full_q  <= (cnt_nxt == FULL_CNT);
    end
  end

  // Return-address storage; entries are not cleared, reset just zeroes the count
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      ras_mem[wr_ptr] <= inc;
    end
  end

  assign pc_out        = pc_q;
  assign ras_empty     = empty_q;
  assign ras_full      = full_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit
module tb_pc_unit;

  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_BR    = 5'b00001;
  localparam logic [4:0] C_JMP   = 5'b00010;
  localparam logic [4:0] C_CALL  = 5'b00100;
  localparam logic [4:0] C_RET   = 5'b01000;
  localparam logic [4:0] C_STALL = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       br_taken = 1'b0;
  logic [5:0] br_offset = '0;
  logic       jmp_en = 1'b0;
  logic       call_en = 1'b0;
  logic       ret_en = 1'b0;
  logic [5:0] jmp_target = '0;
  logic [5:0] pc_out;
  logic [5:0] pc_next;
  logic       ras_empty, ras_full, ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  pc_unit #(.PC_W(6), .RESET_VEC(32), .OFF_W(6), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_offset(br_offset), .jmp_en(jmp_en), .call_en(call_en), .ret_en(ret_en),
    .jmp_target(jmp_target), .pc_out(pc_out), .pc_next(pc_next),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply controls for the coming edge and record the PC it must produce
  task automatic drive(input logic [4:0] c, input logic [5:0] off, input logic [5:0] tgt,
                       input logic [5:0] exp_pc);
    {stall, ret_en, call_en, jmp_en, br_taken} = c;
    br_offset  = off;
    jmp_target = tgt;
    exp_q.push_back(exp_pc);
  endtask

  task automatic test_reset();
    logic [5:0] e;
    reset = 1'b1;
    drive(C_IDLE, 6'd0, 6'd0, 6'd32);
    tick();
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc_out !== e) begin errors++; $display("FAIL reset_pc actual=%0d required=%0d", pc_out, e); end
    checks++;
    if (pc_next !== 6'd32) begin errors++; $display("FAIL reset_pc_next actual=%0d required=32", pc_next); end
    checks++;
    if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags actual=%b required=1000",
               {ras_empty, ras_full, ras_overflow, ras_underflow});
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(C_IDLE, 6'd0, 6'd0, 6'(33 + i));
      #1;
      checks++;
      if (pc_next !== exp_q[0]) begin errors++; $display("FAIL free_pc_next actual=%0d required=%0d", pc_next, exp_q[0]); end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e) begin errors++; $display("FAIL free_run actual=%0d required=%0d", pc_out, e); end
    end
    checks++;
    if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
      errors++;
      $display("FAIL free_flags actual=%b required=1000",
               {ras_empty, ras_full, ras_overflow, ras_underflow});
    end
  endtask

  task automatic test_branch_wrap();
    logic [4:0] c [7];
    logic [5:0] off [7];
    logic [5:0] tgt [7];
    logic [5:0] ex [7];
    logic [5:0] e;
    // jmp 40; br -5 -> 36; jmp 63; idle -> 0; br -5 from 0 -> 60; br +31 -> 28; br 0 -> 29
    c   = '{C_JMP, C_BR, C_JMP, C_IDLE, C_BR, C_BR, C_BR};
    off = '{6'd0, 6'b111011, 6'd0, 6'd0, 6'b111011, 6'b011111, 6'd0};
    tgt = '{6'd40, 6'd0, 6'd63, 6'd0, 6'd0, 6'd0, 6'd0};
    ex  = '{6'd40, 6'd36, 6'd63, 6'd0, 6'd60, 6'd28, 6'd29};
    for (int i = 0; i < 7; i++) begin
      drive(c[i], off[i], tgt[i], ex[i]);
      #1;
      checks++;
      if (pc_next !== exp_q[0]) begin errors++; $display("FAIL br_pc_next step%0d actual=%0d required=%0d", i, pc_next, exp_q[0]); end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e) begin errors++; $display("FAIL br_wrap step%0d actual=%0d required=%0d", i, pc_out, e); end
    end
  endtask

  task automatic test_call_ret();
    logic [4:0] c [5];
    logic [5:0] tgt [5];
    logic [5:0] ex [5];
    logic [3:0] fl [5];
    logic [5:0] e;
    c   = '{C_JMP, C_CALL, C_IDLE, C_IDLE, C_RET};
    tgt = '{6'd10, 6'd50, 6'd0, 6'd0, 6'd0};
    ex  = '{6'd10, 6'd50, 6'd51, 6'd52, 6'd11};
    fl  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      drive(c[i], 6'd0, tgt[i], ex[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e) begin errors++; $display("FAIL call_ret step%0d actual=%0d required=%0d", i, pc_out, e); end
      checks++;
      if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== fl[i]) begin
        errors++;
        $display("FAIL call_ret_flags step%0d actual=%b required=%b", i,
                 {ras_empty, ras_full, ras_overflow, ras_underflow}, fl[i]);
      end
    end
  endtask

  task automatic test_nested();
    logic [4:0] c [11];
    logic [5:0] tgt [11];
    logic [5:0] ex [11];
    logic [3:0] fl [11];
    logic [5:0] e;
    // five calls from PCs 1..5, then five returns; the fifth finds the stack empty
    c   = '{C_JMP, C_CALL, C_CALL, C_CALL, C_CALL, C_CALL, C_RET, C_RET, C_RET, C_RET, C_RET};
    tgt = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd20, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    ex  = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd20, 6'd6, 6'd5, 6'd4, 6'd3, 6'd4};
    fl  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0110,
            4'b0010, 4'b0010, 4'b0010, 4'b1010, 4'b1011};
    for (int i = 0; i < 11; i++) begin
      drive(c[i], 6'd0, tgt[i], ex[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e) begin errors++; $display("FAIL nested step%0d actual=%0d required=%0d", i, pc_out, e); end
      checks++;
      if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== fl[i]) begin
        errors++;
        $display("FAIL nested_flags step%0d actual=%b required=%b", i,
                 {ras_empty, ras_full, ras_overflow, ras_underflow}, fl[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [5:0] e;
    drive(C_JMP, 6'd0, 6'd30, 6'd30);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc_out !== e) begin errors++; $display("FAIL stall_setup_jmp actual=%0d required=%0d", pc_out, e); end
    drive(C_CALL, 6'd0, 6'd45, 6'd45);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc_out !== e) begin errors++; $display("FAIL stall_setup_call actual=%0d required=%0d", pc_out, e); end
    for (int i = 0; i < 3; i++) begin
      drive(C_STALL | C_CALL | C_JMP | C_BR, 6'd3, 6'd12, 6'd45);
      #1;
      checks++;
      if (pc_next !== exp_q[0]) begin errors++; $display("FAIL stall_pc_next cyc%0d actual=%0d required=%0d", i, pc_next, exp_q[0]); end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e) begin errors++; $display("FAIL stall_pc cyc%0d actual=%0d required=%0d", i, pc_out, e); end
      checks++;
      if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b0011) begin
        errors++;
        $display("FAIL stall_flags cyc%0d actual=%b required=0011", i,
                 {ras_empty, ras_full, ras_overflow, ras_underflow});
      end
    end
    // pop wins over call and jump; the stack must end empty, proving no push
    drive(C_RET | C_CALL | C_JMP, 6'd0, 6'd7, 6'd31);
    #1;
    checks++;
    if (pc_next !== exp_q[0]) begin errors++; $display("FAIL prio_pc_next actual=%0d required=%0d", pc_next, exp_q[0]); end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc_out !== e) begin errors++; $display("FAIL prio_pc actual=%0d required=%0d", pc_out, e); end
    checks++;
    if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1011) begin
      errors++;
      $display("FAIL prio_flags actual=%b required=1011",
               {ras_empty, ras_full, ras_overflow, ras_underflow});
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] e;
    drive(C_JMP, 6'd0, 6'd0, 6'd0);
    tick();
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(C_CALL, 6'd0, 6'(i + 1), 6'(i + 1));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e) begin errors++; $display("FAIL fill_call%0d actual=%0d required=%0d", i, pc_out, e); end
    end
    checks++;
    if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b0111) begin
      errors++;
      $display("FAIL prereset_flags actual=%b required=0111",
               {ras_empty, ras_full, ras_overflow, ras_underflow});
    end
    reset = 1'b1;
    drive(C_RET | C_CALL, 6'd0, 6'd9, 6'd32);
    #1;
    checks++;
    if (pc_next !== 6'd32) begin errors++; $display("FAIL midreset_pc_next actual=%0d required=32", pc_next); end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc_out !== e) begin errors++; $display("FAIL midreset_pc actual=%0d required=%0d", pc_out, e); end
    checks++;
    if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_flags actual=%b required=1000",
               {ras_empty, ras_full, ras_overflow, ras_underflow});
    end
    reset = 1'b0;
    drive(C_RET, 6'd0, 6'd0, 6'd33);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc_out !== e) begin errors++; $display("FAIL postreset_ret actual=%0d required=%0d", pc_out, e); end
    checks++;
    if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1001) begin
      errors++;
      $display("FAIL postreset_flags actual=%b required=1001",
               {ras_empty, ras_full, ras_overflow, ras_underflow});
    end
    drive(C_IDLE, 6'd0, 6'd0, 6'd34);
    tick();
  endtask

  initial begin
    test_reset();
    test_branch_wrap();
    test_call_ret();
    test_nested();
    test_stall();
    test_reset_mid();
    e_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // The last idle cycle of test_reset_mid leaves one entry; compare it here
  task automatic e_drain();
    logic [5:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e) begin errors++; $display("FAIL drain actual=%0d required=%0d", pc_out, e); end
    end
  endtask

endmodule
